// File: rtl/speed_pwm_regulator.sv
// Closed-loop speed regulator: integral-style duty update from window counts, fixed-period PWM drive.
// Optional STALL_PROTECT_EN adds a sticky stall trip after repeated zero-speed samples at full duty.
module speed_pwm_regulator #(
  parameter int PWM_PERIOD    = 1000,
  parameter int DUTY_W        = 10,
  parameter int KP_SHIFT      = 2,
  parameter int STALL_SAMPLES = 3
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              speed_valid,
  input  logic [11:0]       speed_cnt,
  input  logic [11:0]       target_speed,
  output logic              pwm_out,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              update_done,
  output logic              stall
);

  // state | meaning
  // IDLE  | waiting for a speed sample
  // ERR   | error target - speed registered
  // ADJ   | scaled error added to duty_cmd and clamped
  // WRITE | duty_cmd written, update_done pulsed
  typedef enum logic [1:0] {IDLE, ERR, ADJ, WRITE} state_t;

  localparam logic [DUTY_W-1:0]  PERIOD_D  = DUTY_W'(PWM_PERIOD);
  localparam logic [DUTY_W-1:0]  PERIOD_M1 = DUTY_W'(PWM_PERIOD - 1);
  localparam logic signed [13:0] PERIOD_S  = 14'(PWM_PERIOD);

  state_t             state, state_nxt;
  logic [11:0]        cap_speed, cap_target;
  logic signed [12:0] err;
  logic signed [13:0] err_x, delta, duty_ext, sum;
  logic [DUTY_W-1:0]  duty_cmd, adj_val, adj_nxt;
  logic [DUTY_W-1:0]  pwm_cnt, duty_r;
  logic               pwm_r, done_r;
  logic               start, lockout, stall_trip;

  assign start = enable & speed_valid & ~lockout;

  always_ff @(posedge clk_in) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nxt = ERR;
      ERR:   state_nxt = ADJ;
      ADJ:   state_nxt = WRITE;
      WRITE: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
    busy = (state != IDLE);
  end

  always_comb begin
    err_x    = {err[12], err};
    delta    = err_x >>> KP_SHIFT;
    duty_ext = {{(14-DUTY_W){1'b0}}, duty_cmd};
    sum      = duty_ext + delta;
    if (sum[13])             adj_nxt = '0;
    else if (sum > PERIOD_S) adj_nxt = PERIOD_D;
    else                     adj_nxt = sum[DUTY_W-1:0];
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n || !enable) begin
      cap_speed  <= '0;
      cap_target <= '0;
      err        <= '0;
      adj_val    <= '0;
      duty_cmd   <= '0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cap_speed  <= speed_cnt;
            cap_target <= target_speed;
          end
        end
        ERR:   err     <= $signed({1'b0, cap_target}) - $signed({1'b0, cap_speed});
        ADJ:   adj_val <= adj_nxt;
        WRITE: begin
          duty_cmd <= stall_trip ? '0 : adj_val;
          done_r   <= 1'b1;
        end
      endcase
    end
  end

  // New duty is only picked up on the last count so a period is never cut short.
  always_ff @(posedge clk_in) begin
    if (!rst_n || !enable) begin
      pwm_cnt <= '0;
      duty_r  <= '0;
      pwm_r   <= 1'b0;
    end else begin
      pwm_r <= (pwm_cnt < duty_r);
      if (pwm_cnt == PERIOD_M1) begin
        pwm_cnt <= '0;
        duty_r  <= duty_cmd;
      end else begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
    end
  end

`ifdef STALL_PROTECT_EN
  localparam int SC_W = $clog2(STALL_SAMPLES + 1);

  logic [SC_W-1:0] stall_cnt;
  logic            stall_r, stalled_sample;

  assign stalled_sample = (cap_speed == 12'd0) && (duty_cmd == PERIOD_D);
  assign stall_trip     = (state == WRITE) && stalled_sample &&
                          (stall_cnt == SC_W'(STALL_SAMPLES - 1));

  always_ff @(posedge clk_in) begin
    if (!rst_n || !enable) begin
      stall_cnt <= '0;
      stall_r   <= 1'b0;
    end else if (state == WRITE) begin
      if (!stalled_sample)  stall_cnt <= '0;
      else if (stall_trip)  stall_r   <= 1'b1;
      else                  stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign lockout = stall_r;
  assign stall   = stall_r;
`else
  assign stall_trip = 1'b0;
  assign lockout    = 1'b0;
  assign stall      = 1'b0;
`endif

  assign pwm_out     = pwm_r;
  assign duty        = duty_r;
  assign update_done = done_r;

endmodule

// File: tb/tb_speed_pwm_regulator.sv
// Directed bench for speed_pwm_regulator; expected duty_cmd values are queued per strobe and
// popped when update_done pulses. Build with +define+STALL_PROTECT_EN to exercise the stall trip.
module tb_speed_pwm_regulator;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        speed_valid = 1'b0;
  logic [11:0] speed_cnt = '0;
  logic [11:0] target_speed = '0;
  logic        pwm_out;
  logic [9:0]  duty;
  logic        busy;
  logic        update_done;
  logic        stall;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int sb[$];

  int exp_cmd = 0;
  int exp_scnt = 0;
  bit exp_stall = 1'b0;
  bit exp_lock = 1'b0;

  speed_pwm_regulator dut (
    .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .speed_valid(speed_valid),
    .speed_cnt(speed_cnt), .target_speed(target_speed), .pwm_out(pwm_out),
    .duty(duty), .busy(busy), .update_done(update_done), .stall(stall)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: each update_done must match the oldest queued expectation.
  always @(negedge clk_in) begin
    if (update_done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_update", 32'd1, 32'd0);
      end else begin
        chk("duty_cmd", dut.duty_cmd, sb.pop_front());
      end
    end
  end

  task automatic model_push(input int t, input int s, output bit upd);
    int sum;
    if (exp_lock) begin
      upd = 1'b0;
      return;
    end
    sum = exp_cmd + ((t - s) >>> 2);
    if (sum < 0) sum = 0;
    else if (sum > 1000) sum = 1000;
`ifdef STALL_PROTECT_EN
    if (s == 0 && exp_cmd == 1000) begin
      exp_scnt++;
      if (exp_scnt == 3) begin
        exp_stall = 1'b1;
        exp_lock  = 1'b1;
        sum       = 0;
      end
    end else begin
      exp_scnt = 0;
    end
`endif
    exp_cmd = sum;
    sb.push_back(sum);
    upd = 1'b1;
  endtask

  task automatic model_disable();
    exp_cmd   = 0;
    exp_scnt  = 0;
    exp_stall = 1'b0;
    exp_lock  = 1'b0;
  endtask

  task automatic do_strobe(input int t, input int s);
    bit upd;
    int lat;
    model_push(t, s, upd);
    @(negedge clk_in);
    target_speed = t[11:0];
    speed_cnt    = s[11:0];
    speed_valid  = 1'b1;
    @(posedge clk_in);
    #1 speed_valid = 1'b0;
    chk("busy_after_strobe", busy, upd);
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk_in);
      #1;
      if (update_done === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("update_latency", lat, upd ? 3 : -1);
    chk("stall_flag", stall, exp_stall);
  endtask

  task automatic check_period(input int exp_duty);
    int n;
    repeat (2000) @(negedge clk_in);
    n = 0;
    repeat (1000) begin
      @(negedge clk_in);
      if (pwm_out === 1'b1) n++;
    end
    chk("pwm_high_count", n, exp_duty);
    chk("duty_port", duty, exp_duty);
  endtask

  initial begin
    int d0;
    bit upd;

    // Reset held with random inputs
    rst_n = 1'b0;
    repeat (2) @(posedge clk_in);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_in);
      chk("reset_outputs", {pwm_out, duty, busy, update_done, stall}, 0);
      enable       = 1'($urandom);
      speed_valid  = 1'($urandom);
      speed_cnt    = 12'($urandom);
      target_speed = 12'($urandom);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    enable = 1'b1;
    speed_valid = 1'b0;
    model_disable();

    // Basic update and clamps
    do_strobe(400, 0);
    check_period(100);
    do_strobe(0, 800);
    check_period(0);
    do_strobe(4095, 0);
    do_strobe(4095, 0);
    check_period(1000);

    // Strobe while busy is dropped
    d0 = done_cnt;
    model_push(0, 400, upd);
    @(negedge clk_in);
    target_speed = 12'd0;
    speed_cnt    = 12'd400;
    speed_valid  = 1'b1;
    @(posedge clk_in);
    #1;
    target_speed = 12'd4095;
    speed_cnt    = 12'd0;
    @(posedge clk_in);
    #1 speed_valid = 1'b0;
    repeat (8) @(posedge clk_in);
    #1 chk("dropped_update_count", done_cnt - d0, 1);
    check_period(900);

    // Enable dropped while in ADJ
    d0 = done_cnt;
    @(negedge clk_in);
    target_speed = 12'd4095;
    speed_cnt    = 12'd0;
    speed_valid  = 1'b1;
    @(posedge clk_in);
    #1 speed_valid = 1'b0;
    @(posedge clk_in);
    #1 chk("busy_in_adj", busy, 1);
    @(negedge clk_in);
    enable = 1'b0;
    model_disable();
    @(posedge clk_in);
    #1;
    chk("abort_duty", duty, 0);
    chk("abort_pwm", pwm_out, 0);
    chk("abort_busy", busy, 0);
    repeat (8) @(posedge clk_in);
    #1 chk("abort_no_update", done_cnt - d0, 0);
    @(negedge clk_in);
    enable = 1'b1;
    do_strobe(400, 0);
    check_period(100);

    // Stall sequence
    repeat (4) do_strobe(4095, 0);
    check_period(exp_stall ? 0 : 1000);
    do_strobe(4095, 0);
    @(negedge clk_in);
    enable = 1'b0;
    model_disable();
    @(negedge clk_in);
    chk("stall_cleared", stall, 0);
    enable = 1'b1;
    do_strobe(400, 0);

    repeat (4) @(negedge clk_in);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
